tdm_demux: RTL and testbench
============================

// Module: tdm_demux
//
// PURPOSE
//   Receive end of a time-division-multiplexed sample stream. A sender muxes
//   N_CH channels onto one W-bit bus, one sample per valid cycle, and flags
//   channel 0 with in_first. This block locks to that framing and routes each
//   sample into its channel slot. It presents each complete frame as one
//   parallel word and flags framing errors.
//
// PARAMETERS
//   N_CH  4  channels per frame (>= 2)
//   W     8  bits per sample
//
// PORTS
//   clk        in   1                        rising-edge clock
//   rst        in   1                        synchronous, active-high reset
//   in_valid   in   1                        in_data/in_first valid this cycle
//   in_first   in   1                        sample is channel 0 (frame start)
//   in_data    in   W                        sample payload
//   out_data   out  N_CH*W                   last complete frame; ch k at [k*W +: W]
//   out_valid  out  1                        1-cycle pulse: new frame on out_data
//   out_err    out  1                        1-cycle pulse: framing/parity error
//   out_locked out  1                        1 = state LOCKED
//   out_ch     out  $clog2(N_CH)             slot the next accepted sample fills
//
// BEHAVIOUR
//   - Reset, synchronous, dominant over all inputs:
//     - outputs: out_data=0, out_valid=0, out_err=0, out_locked=0, out_ch=0.
//     - internal: shadow frame = 0, state = HUNT.
//   - Only cycles with in_valid=1 are acted on. Cycles with in_valid=0 change
//     no state, and out_valid/out_err return to 0.
//   - HUNT:
//     - sample with in_first=0: dropped, no error.
//     - sample with in_first=1: write to shadow slot 0, set out_ch=1, go to LOCKED.
//   - LOCKED, out_ch==0:
//     - in_first=1: write slot 0, set out_ch=1.
//     - in_first=0: missing frame start. Drop the sample, pulse out_err,
//       go to HUNT.
//   - LOCKED, 0<out_ch<N_CH-1:
//     - in_first=0: write slot out_ch, then out_ch+1.
//     - in_first=1: early frame start. Pulse out_err, discard the partial
//       frame, write this sample to slot 0, set out_ch=1, stay LOCKED.
//   - LOCKED, out_ch==N_CH-1:
//     - in_first=0: complete frame. On the same edge:
//       - out_data <= shadow with slot N_CH-1 replaced by in_data;
//       - out_valid <= 1; out_ch wraps to 0.
//     - in_first=1: handled as an early frame start (above).
//   - Latency: out_valid and the new out_data appear in the cycle after the
//     edge that accepts the last sample (1 cycle).
//   - out_data holds its value between frames. It never shows a partial
//     frame.
//   - Back-to-back frames with in_valid=1 every cycle sustain one out_valid
//     every N_CH cycles.
//   - out_valid and out_err are never both 1 in the same cycle, except a
//     parity error on the final sample (see CONFIGURATION), which pulses
//     out_err only.
//   - Reset during a frame: the partial frame is lost, state returns to
//     HUNT, out_data is cleared.
//
// CONFIGURATION
//   TDM_DEMUX_PARITY_EN
//   - Defined:
//     - adds input port in_parity (1 bit), even parity over {in_data,in_parity}.
//     - a mismatch on any accepted sample marks the current frame bad and
//       pulses out_err in the cycle after.
//     - a bad frame never raises out_valid and never updates out_data.
//     - framing state is unaffected by a parity error.
//     - a new frame start clears the bad mark.
//   - Undefined: no in_parity port, no parity checking.
//
// TESTING  (N_CH=4, W=8)
//   1. rst=1 for 2 cycles with random inputs -> all outputs 0, out_locked=0.
//   2. Frame 0x11(first),0x22,0x33,0x44 on consecutive cycles
//      -> one cycle later out_valid=1, out_data=0x44332211; then out_valid=0.
//   3. Samples 0xAA,0xBB with in_first=0 while in HUNT -> dropped, no out_err.
//      Then a good frame -> locks, out_valid=1.
//   4. 0x11(first),0x22, then 0x55(first),0x66,0x77,0x88
//      -> out_err pulse on the 3rd sample, then out_data=0x88776655 with
//         out_valid; out_data from before the sequence held until then.
//   5. Two frames with in_valid gaps of 0..3 idle cycles between samples
//      -> exactly two out_valid pulses, data correct.
//      Then a sample with in_first=0 at out_ch==0 -> out_err, out_locked=0.
//   6. (TDM_DEMUX_PARITY_EN) Good frame, then a frame with bad parity on
//      sample 2 -> out_err pulse, no out_valid, out_data keeps the first frame.
//      Next good frame -> out_valid.

Source files
------------

// File: rtl/tdm_demux.sv
// TDM receive demultiplexer: locks to channel-0 framing and presents each complete frame as one word.
// Optional macro TDM_DEMUX_PARITY_EN adds in_parity and even-parity frame rejection.
module tdm_demux #(
    parameter int N_CH = 4,
    parameter int W    = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    input  logic                      in_first,
    input  logic [W-1:0]              in_data,
`ifdef TDM_DEMUX_PARITY_EN
    input  logic                      in_parity,
`endif
    output logic [N_CH*W-1:0]         out_data,
    output logic                      out_valid,
    output logic                      out_err,
    output logic                      out_locked,
    output logic [$clog2(N_CH)-1:0]   out_ch
);

    localparam int CW = $clog2(N_CH);

    typedef enum logic {HUNT, LOCKED} state_t;

    state_t              state, state_n;
    logic [N_CH*W-1:0]   shadow, shadow_n;
    logic [N_CH*W-1:0]   data_n;
    logic [CW-1:0]       ch_n;
    logic                valid_n, err_n;
    logic                bad, bad_n;
    logic                perr;

`ifdef TDM_DEMUX_PARITY_EN
    assign perr = ^{in_data, in_parity};
`else
    assign perr = 1'b0;
`endif

    assign out_locked = (state == LOCKED);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= HUNT;
            shadow    <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            out_err   <= 1'b0;
            out_ch    <= '0;
            bad       <= 1'b0;
        end else begin
            state     <= state_n;
            shadow    <= shadow_n;
            out_data  <= data_n;
            out_valid <= valid_n;
            out_err   <= err_n;
            out_ch    <= ch_n;
            bad       <= bad_n;
        end
    end

    always_comb begin
        state_n  = state;
        shadow_n = shadow;
        data_n   = out_data;
        valid_n  = 1'b0;
        err_n    = 1'b0;
        ch_n     = out_ch;
        bad_n    = bad;
        if (in_valid) begin
            case (state)
                HUNT: begin
                    if (in_first) begin
                        shadow_n[0 +: W] = in_data;
                        ch_n             = CW'(1);
                        state_n          = LOCKED;
                        bad_n            = perr;
                        err_n            = perr;
                    end
                end
                default: begin
                    if (in_first) begin
                        // Any frame start restarts the frame; it is an error unless we expected it.
                        shadow_n[0 +: W] = in_data;
                        ch_n             = CW'(1);
                        bad_n            = perr;
                        err_n            = (out_ch != '0) | perr;
                    end else if (out_ch == '0) begin
                        err_n   = 1'b1;
                        state_n = HUNT;
                    end else if (out_ch == CW'(N_CH - 1)) begin
                        ch_n  = '0;
                        err_n = perr;
                        bad_n = bad | perr;
                        if (!bad && !perr) begin
                            data_n                     = shadow;
                            data_n[(N_CH-1)*W +: W]    = in_data;
                            valid_n                    = 1'b1;
                        end
                    end else begin
                        shadow_n[out_ch*W +: W] = in_data;
                        ch_n                    = out_ch + CW'(1);
                        err_n                   = perr;
                        bad_n                   = bad | perr;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tdm_demux.sv
// Randomized self-checking bench for tdm_demux against a queue-based frame model.
module tb_tdm_demux;

    localparam int N_CH = 4;
    localparam int W    = 8;
`ifdef TDM_DEMUX_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              in_valid = 1'b0;
    logic              in_first = 1'b0;
    logic [W-1:0]      in_data = '0;
    logic              in_parity = 1'b0;
    logic [N_CH*W-1:0] out_data;
    logic              out_valid, out_err, out_locked;
    logic [1:0]        out_ch;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [W-1:0]      frame[$];
    bit                m_locked = 1'b0;
    bit                m_bad = 1'b0;
    logic [N_CH*W-1:0] m_data = '0;
    bit                exp_valid, exp_err;

    tdm_demux #(.N_CH(N_CH), .W(W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_first(in_first), .in_data(in_data),
`ifdef TDM_DEMUX_PARITY_EN
        .in_parity(in_parity),
`endif
        .out_data(out_data), .out_valid(out_valid), .out_err(out_err),
        .out_locked(out_locked), .out_ch(out_ch)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all();
        check("valid", 64'(out_valid), 64'(exp_valid));
        check("err", 64'(out_err), 64'(exp_err));
        check("locked", 64'(out_locked), 64'(m_locked));
        check("ch", 64'(out_ch), 64'(frame.size()));
        check("data", 64'(out_data), 64'(m_data));
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        for (int i = 0; i < n; i++) begin
            in_valid = 1'($urandom); in_first = 1'($urandom);
            in_data = 8'($urandom); in_parity = 1'($urandom);
            @(posedge clk); #1;
            frame.delete(); m_locked = 0; m_bad = 0; m_data = '0;
            exp_valid = 0; exp_err = 0;
            check_all();
        end
        rst = 1'b0;
    endtask

    // pb=1 drives a wrong parity bit (only meaningful when parity is built in)
    task automatic step(input bit v, input bit f, input logic [W-1:0] d, input bit pb);
        bit acc;
        in_valid = v; in_first = f; in_data = d; in_parity = (^d) ^ pb;
        @(posedge clk); #1;
        exp_valid = 0; exp_err = 0; acc = 0;
        if (v) begin
            if (!m_locked) begin
                if (f) begin frame = {d}; m_locked = 1; m_bad = 0; acc = 1; end
            end else if (f) begin
                exp_err = (frame.size() != 0);
                frame = {d}; m_bad = 0; acc = 1;
            end else if (frame.size() == 0) begin
                exp_err = 1; m_locked = 0;
            end else begin
                frame.push_back(d); acc = 1;
            end
            if (acc && pb && PAR) begin exp_err = 1; m_bad = 1; end
            if (frame.size() == N_CH) begin
                if (!m_bad) begin
                    for (int k = 0; k < N_CH; k++) m_data[k*W +: W] = frame[k];
                    exp_valid = 1;
                end
                frame.delete();
            end
        end
        check_all();
    endtask

    task automatic good_frame(input logic [N_CH*W-1:0] w, input int maxgap);
        for (int k = 0; k < N_CH; k++) begin
            int g = $urandom_range(0, maxgap);
            for (int j = 0; j < g; j++) step(0, 0, 8'($urandom), 0);
            step(1, (k == 0), w[k*W +: W], 0);
        end
    endtask

    initial begin
        int pulses;
        do_reset(2);

        good_frame(32'h44332211, 0);
        check("t2_data", 64'(out_data), 64'h44332211);
        check("t2_pulse", 64'(out_valid), 64'd1);
        step(0, 0, 8'h00, 0);
        check("t2_after", 64'(out_valid), 64'd0);

        do_reset(1);
        step(1, 0, 8'hAA, 0);
        step(1, 0, 8'hBB, 0);
        check("t3_hunt", 64'(out_locked), 64'd0);
        good_frame(32'hD4C3B2A1, 0);
        check("t3_valid", 64'(out_valid), 64'd1);

        step(1, 1, 8'h11, 0);
        step(1, 0, 8'h22, 0);
        step(1, 1, 8'h55, 0);
        check("t4_err", 64'(out_err), 64'd1);
        check("t4_hold", 64'(out_data), 64'hD4C3B2A1);
        step(1, 0, 8'h66, 0);
        step(1, 0, 8'h77, 0);
        step(1, 0, 8'h88, 0);
        check("t4_data", 64'(out_data), 64'h88776655);

        pulses = 0;
        for (int f = 0; f < 2; f++) begin
            for (int k = 0; k < N_CH; k++) begin
                int g = $urandom_range(0, 3);
                for (int j = 0; j < g; j++) begin
                    step(0, 0, 8'($urandom), 0);
                    pulses += int'(out_valid);
                end
                step(1, (k == 0), 8'(16 * f + k + 1), 0);
                pulses += int'(out_valid);
            end
        end
        check("t5_pulses", 64'(pulses), 64'd2);
        check("t5_data", 64'(out_data), 64'h14131211);
        step(1, 0, 8'h99, 0);
        check("t5_err", 64'(out_err), 64'd1);
        check("t5_unlock", 64'(out_locked), 64'd0);

`ifdef TDM_DEMUX_PARITY_EN
        good_frame(32'h04030201, 0);
        step(1, 1, 8'hE1, 0);
        step(1, 0, 8'hE2, 1);
        check("t6_err", 64'(out_err), 64'd1);
        step(1, 0, 8'hE3, 0);
        step(1, 0, 8'hE4, 0);
        check("t6_novalid", 64'(out_valid), 64'd0);
        check("t6_hold", 64'(out_data), 64'h04030201);
        good_frame(32'h0C0B0A09, 0);
        check("t6_valid", 64'(out_valid), 64'd1);
`endif

        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 99) == 0) do_reset(1);
            else step($urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0,
                      8'($urandom), $urandom_range(0, 15) == 0);
        end
        for (int i = 0; i < 20; i++) good_frame(32'($urandom), 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
